contador_decrescente: RTL
=========================

Name: contador_decrescente

Overview:
Programmable down-counter/timer, the decrementing counterpart of the team's free-running 4-bit up-counter. It loads a start value on a start pulse and counts down once per enabled clock. At terminal count it emits a one-cycle done pulse, then either stops or auto-reloads. It serves as a timer/delay generator for sequencing logic in the digital electronics lab designs.

Parameters:
WIDTH, 4, bit width of load value and count.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  load load_val and begin counting; sampled on clk rising edge.
stop  input  1  abort counting; sampled on clk rising edge.
en  input  1  count enable; decrement only when high.
auto_reload  input  1  1 = reload and continue at terminal count; 0 = one-shot.
load_val  input  WIDTH  start value captured on start.
count  output  WIDTH  current count value (registered).
busy  output  1  high while in RUN (registered).
done  output  1  one-cycle pulse at terminal count (registered).

Behaviour:
- Reset (rst_n=0, async, no clock needed): count=0, busy=0, done=0, reload_reg=0, state=IDLE. Deassertion is synchronous to clk by upstream logic, not by this block.
- States: IDLE, RUN. busy = (state==RUN).
- done defaults to 0 every cycle; it is high only in the cycle after a terminal-count event.
- IDLE:
  - start=1, load_val!=0: count<=load_val, reload_reg<=load_val, state<=RUN.
  - start=1, load_val==0: count<=0, done<=1, stay IDLE.
  - Otherwise hold count. en, stop and auto_reload are ignored.
- RUN, in priority order:
  1. start=1: restart. count<=load_val, reload_reg<=load_val, stay RUN. If load_val==0, go to IDLE with done<=1. start wins over stop and over en.
  2. stop=1: state<=IDLE, count holds its current value, no done.
  3. en=0: hold everything.
  4. en=1, count>1: count<=count-1.
  5. en=1, count==1 (terminal): done<=1.
     - auto_reload=1: count<=reload_reg, stay RUN.
     - auto_reload=0: count<=0, state<=IDLE.
- Latency and period:
  - With load N (N>=1) and en held high, done is high exactly N cycles after the edge that captured start.
  - One-shot: count shows N, N-1, ..., 1, then 0 with done=1 in that same cycle.
  - Auto-reload: count shows N..1 repeating and never 0. done pulses every N enabled cycles.
- auto_reload is sampled only at the terminal cycle, so changing it mid-count takes effect at the next terminal.
- Arithmetic: unsigned, WIDTH bits. Decrement never underflows, because count==0 is never decremented in RUN. Maximum load 2^WIDTH-1.
- Reset mid-RUN: immediate return to reset values. A done pending on that edge is lost.

Decomposition:
- Shared package contador_pkg: state encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1. The up-counter may reuse the package.
- No sub-module. Single always block for state/count/done plus a continuous assignment for busy.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> count=0, busy=0 and done=0 immediately, without waiting for a clock edge.
- One-shot: load_val=5, start pulse, en=1, auto_reload=0 -> count 5,4,3,2,1,0; done=1 only in the cycle count=0; busy falls the same cycle; count stays 0 afterwards.
- Auto-reload and gating: load_val=3, auto_reload=1, en=1 -> count 3,2,1,3,2,1,...; done pulses every 3 cycles. Drop en for 2 cycles mid-count -> count holds and the done period stretches by 2.
- Abort and restart: load_val=9, at count=6 assert stop -> IDLE, count holds 6, no done. Then assert start and stop together with load_val=4 -> RUN, count=4.
- Boundaries: start with load_val=0 -> done pulse, busy stays 0. load_val=15 with WIDTH=4 -> 15 enabled cycles to done, no underflow or wrap through 15.
- Async reset mid-count: rst_n=0 at count=2 -> outputs cleared without a clock edge; after release, nothing happens until the next start.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared definitions for the lab counter family (down-counter and up-counter).
// State encoding is kept as plain one-bit localparams so both counters agree on it.
package contador_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/contador_decrescente.sv
// Programmable down-counter / timer.
// A start pulse captures load_val and the block counts down once per enabled clock.
// At terminal count it emits a one-cycle done pulse. It then either stops (one-shot)
// or reloads the captured start value and keeps running (auto_reload).
import contador_pkg::*;

module contador_decrescente #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic             state;
  logic [WIDTH-1:0] reload_reg;

  // State, count, reload value and done pulse; start has priority over stop and en in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            count      <= load_val;
            reload_reg <= load_val;
            if (load_val != ZERO) begin
              state <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (start) begin
            count      <= load_val;
            reload_reg <= load_val;
            if (load_val == ZERO) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end else if (stop) begin
            state <= ST_IDLE;
          end else if (en) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else if (count == ONE) begin
              done <= 1'b1;
              if (auto_reload) begin
                count <= reload_reg;
              end else begin
                count <= ZERO;
                state <= ST_IDLE;
              end
            end else begin
              // A zero count in RUN cannot be reached; fall back to IDLE rather than wrap
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);

endmodule
